// File: rtl/display_scan_mux_pkg.sv
// rtl/display_scan_mux_pkg.sv - shared types and anode polarity helpers for the display scanner
package display_pkg;

   localparam int MAX_DIGITS = 8;

   typedef logic [$clog2(MAX_DIGITS)-1:0] digit_idx_t;

   function automatic logic anode_on(bit active_low);
      return ~active_low;
   endfunction

   function automatic logic anode_off(bit active_low);
      return active_low;
   endfunction

   // One bit of the one-hot anode vector; en = 0 forces the whole vector inactive.
   function automatic logic onehot_anode(digit_idx_t sel, digit_idx_t pos, bit active_low, bit en);
      return (en && (sel == pos)) ? anode_on(active_low) : anode_off(active_low);
   endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// rtl/display_scan_mux_if.sv - value input and scan outputs of the display scanner
interface display_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] value;
   logic                    value_valid;
   logic [3:0]              sw;
   logic [NUM_DIGITS-1:0]   anodes;
   logic                    blank;
   logic                    frame_done;

   modport master (output value, value_valid, input sw, anodes, blank, frame_done);
   modport slave  (input value, value_valid, output sw, anodes, blank, frame_done);
endinterface

// File: rtl/display_scan_mux_tick_gen.sv
// rtl/display_scan_mux_tick_gen.sv - per-digit dwell prescaler, tick on the last cycle of each slot
module tick_gen #(
   parameter int DIV = 10000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == LAST);

   always_comb begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/display_scan_mux.sv
// rtl/display_scan_mux.sv - multi-digit scanner with frame-synchronous value update
// Optional leading-zero blanking: SCAN_LEADING_ZERO_BLANK_EN
module display_scan_mux
   import display_pkg::*;
#(
   parameter int NUM_DIGITS       = 4,
   parameter int DIV              = 10000,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input logic              clk,
   input logic              rst,
   display_scan_mux_if.slave scan_if
);
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int VW    = 4 * NUM_DIGITS;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic                  tick;
   logic                  boundary;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [VW-1:0]         pending_q, pending_d;
   logic [VW-1:0]         shadow_q, shadow_d;
   logic [3:0]            sw_q, sw_d;
   logic [NUM_DIGITS-1:0] anodes_q, anodes_d;
   logic                  blank_q, blank_d;
   logic                  frame_done_q;

   tick_gen #(.DIV(DIV)) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // A write landing on the boundary cycle bypasses pending straight into shadow.
   always_comb begin
      boundary  = tick && (idx_q == LAST_IDX);
      idx_d     = idx_q;
      if (tick) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      pending_d = scan_if.value_valid ? scan_if.value : pending_q;
      shadow_d  = shadow_q;
      if (boundary) shadow_d = scan_if.value_valid ? scan_if.value : pending_q;
   end

`ifdef SCAN_LEADING_ZERO_BLANK_EN
   always_comb begin
      blank_d = (idx_d != '0) && ((shadow_d >> {idx_d, 2'b00}) == '0);
   end
`else
   always_comb begin
      blank_d = 1'b0;
   end
`endif

   // Outputs come from next-state so sw and anodes switch on the same edge as idx.
   always_comb begin
      sw_d = blank_d ? 4'h0 : shadow_d[{idx_d, 2'b00} +: 4];
      for (int i = 0; i < NUM_DIGITS; i++) begin
         anodes_d[i] = onehot_anode(digit_idx_t'(idx_d), digit_idx_t'(i), ANODE_ACTIVE_LOW, !blank_d);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q        <= '0;
         pending_q    <= '0;
         shadow_q     <= '0;
         sw_q         <= 4'h0;
         anodes_q     <= {NUM_DIGITS{anode_off(ANODE_ACTIVE_LOW)}};
         blank_q      <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         sw_q         <= sw_d;
         anodes_q     <= anodes_d;
         blank_q      <= blank_d;
         frame_done_q <= boundary;
      end
   end

   assign scan_if.sw         = sw_q;
   assign scan_if.anodes     = anodes_q;
   assign scan_if.blank      = blank_q;
   assign scan_if.frame_done = frame_done_q;
endmodule
